// File: rtl/pipelined_mac_unit.sv
// pipelined_mac_unit
// Three-stage pipelined multiply-accumulate for the PE datapath:
//   S1 forms the partial products and reduces them with a carry-save tree,
//   S2 resolves sum + carry with a carry-propagate adder,
//   S3 extends the product and optionally accumulates psum_in, with wrap or
//      saturate handling on overflow.
// A valid/ready handshake freezes the whole pipeline whenever the output
// holds a result that downstream has not taken.

module pipelined_mac_unit #(
   parameter int IN1_WIDTH = 8,
   parameter int IN2_WIDTH = 8,
   parameter int ACC_WIDTH = 20,
   parameter bit SATURATE  = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN1_WIDTH-1:0] in1,
   input  logic [IN2_WIDTH-1:0] in2,
   input  logic [ACC_WIDTH-1:0] psum_in,
   input  logic                 acc_en,
   input  logic                 signed_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] psum_out,
   output logic                 overflow
);

   // Full product width and number of rows entering the carry-save tree:
   // one row per multiplier bit plus a correction row that carries the +1
   // of the negated MSB row in signed mode.
   localparam int P  = IN1_WIDTH + IN2_WIDTH;
   localparam int NR = IN2_WIDTH + 1;

   localparam logic [ACC_WIDTH-1:0] SIGNED_MAX   = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] SIGNED_MIN   = {1'b1, {(ACC_WIDTH-1){1'b0}}};
   localparam logic [ACC_WIDTH-1:0] UNSIGNED_MAX = {ACC_WIDTH{1'b1}};

   // Parameter sanity checks, evaluated at elaboration
   if (IN1_WIDTH < 2) begin : g_bad_in1
      $error("pipelined_mac_unit: IN1_WIDTH must be at least 2");
   end
   if (IN2_WIDTH < 2) begin : g_bad_in2
      $error("pipelined_mac_unit: IN2_WIDTH must be at least 2");
   end
   if (ACC_WIDTH < P) begin : g_bad_acc
      $error("pipelined_mac_unit: ACC_WIDTH must be >= IN1_WIDTH + IN2_WIDTH");
   end

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   logic stall;
   logic accept;

   assign stall    = out_valid && !out_ready;
   assign in_ready = rst_n && !stall;
   assign accept   = in_valid && in_ready;

   // ------------------------------------------------------------------
   // Stage 1: partial products and carry-save reduction
   // ------------------------------------------------------------------
   logic [P-1:0] in1_ext;
   logic [P-1:0] pp_rows [NR];
   logic [P-1:0] csa_sum;
   logic [P-1:0] csa_carry;

   // Build one shifted multiplicand row per multiplier bit; in signed mode
   // the MSB row has negative weight, so it is inverted and +1 is injected
   // through the extra correction row.
   always_comb begin
      // NOTE: every combinational output gets a value before any branch;
      // a path that leaves one unassigned would infer a latch.
      in1_ext = signed_mode ? P'($signed(in1)) : P'(in1);
      for (int j = 0; j < IN2_WIDTH; j++) begin
         pp_rows[j] = in2[j] ? (in1_ext << j) : '0;
      end
      pp_rows[NR-1] = '0;
      if (signed_mode && in2[IN2_WIDTH-1]) begin
         pp_rows[IN2_WIDTH-1] = ~(in1_ext << (IN2_WIDTH-1));
         pp_rows[NR-1]        = P'(1);
      end
   end

   // Wallace-style reduction: each level compresses every full group of
   // three rows into a sum row and a shifted carry row, passing leftovers
   // through untouched, until only two rows remain.
   always_comb begin : csa_tree
      logic [P-1:0] cur [NR];
      logic [P-1:0] nxt [NR];
      int           n_cur;
      int           n_nxt;
      // NOTE: blocking assignments here because each level reads the rows
      // just produced by the previous level within the same evaluation.
      cur   = pp_rows;
      nxt   = pp_rows;
      n_cur = NR;
      n_nxt = NR;
      for (int lvl = 0; lvl < NR; lvl++) begin
         if (n_cur > 2) begin
            n_nxt = 0;
            for (int g = 0; g < NR / 3; g++) begin
               if (3 * g + 2 < n_cur) begin
                  nxt[n_nxt]     = cur[3*g] ^ cur[3*g+1] ^ cur[3*g+2];
                  nxt[n_nxt + 1] = ((cur[3*g]   & cur[3*g+1]) |
                                    (cur[3*g]   & cur[3*g+2]) |
                                    (cur[3*g+1] & cur[3*g+2])) << 1;
                  n_nxt          = n_nxt + 2;
               end
            end
            for (int r = 0; r < NR; r++) begin
               if (r >= n_cur - (n_cur % 3) && r < n_cur) begin
                  nxt[n_nxt] = cur[r];
                  n_nxt      = n_nxt + 1;
               end
            end
            cur   = nxt;
            n_cur = n_nxt;
         end
      end
      csa_sum   = cur[0];
      csa_carry = cur[1];
   end

   logic                 s1_valid;
   logic [P-1:0]         s1_sum;
   logic [P-1:0]         s1_carry;
   logic [ACC_WIDTH-1:0] s1_psum;
   logic                 s1_acc_en;
   logic                 s1_signed;

   // Stage-1 register: capture the sum/carry pair and the item's side info
   always_ff @(posedge clk) begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // stage samples the values from before this clock edge.
      if (!rst_n) begin
         // NOTE: datapath registers are cleared as well as valids, so a
         // freshly reset unit shows psum_out = 0 and carries no stale data.
         s1_valid  <= 1'b0;
         s1_sum    <= '0;
         s1_carry  <= '0;
         s1_psum   <= '0;
         s1_acc_en <= 1'b0;
         s1_signed <= 1'b0;
      end else if (!stall) begin
         s1_valid <= accept;
         if (accept) begin
            s1_sum    <= csa_sum;
            s1_carry  <= csa_carry;
            s1_psum   <= psum_in;
            s1_acc_en <= acc_en;
            s1_signed <= signed_mode;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: carry-propagate add
   // ------------------------------------------------------------------
   logic                 s2_valid;
   logic [P-1:0]         s2_product;
   logic [ACC_WIDTH-1:0] s2_psum;
   logic                 s2_acc_en;
   logic                 s2_signed;

   // Stage-2 register: resolve sum + carry into the P-bit product
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_valid   <= 1'b0;
         s2_product <= '0;
         s2_psum    <= '0;
         s2_acc_en  <= 1'b0;
         s2_signed  <= 1'b0;
      end else if (!stall) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_product <= s1_sum + s1_carry;
            s2_psum    <= s1_psum;
            s2_acc_en  <= s1_acc_en;
            s2_signed  <= s1_signed;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 3: extend, accumulate, overflow handling
   // ------------------------------------------------------------------
   logic [ACC_WIDTH-1:0] prod_ext;
   logic [ACC_WIDTH:0]   acc_wide;
   logic [ACC_WIDTH-1:0] acc_result;
   logic                 acc_ovf;

   // Add the extended product to psum_in one bit wider than the result so
   // the unsigned carry-out is visible; pick wrap or clamp on overflow.
   always_comb begin
      prod_ext   = s2_signed ? ACC_WIDTH'($signed(s2_product)) : ACC_WIDTH'(s2_product);
      acc_wide   = {1'b0, prod_ext} + {1'b0, s2_psum};
      acc_result = prod_ext;
      acc_ovf    = 1'b0;
      if (s2_acc_en) begin
         acc_result = acc_wide[ACC_WIDTH-1:0];
         if (s2_signed) begin
            acc_ovf = (prod_ext[ACC_WIDTH-1] == s2_psum[ACC_WIDTH-1]) &&
                      (acc_wide[ACC_WIDTH-1] != prod_ext[ACC_WIDTH-1]);
         end else begin
            acc_ovf = acc_wide[ACC_WIDTH];
         end
         if (SATURATE && acc_ovf) begin
            if (s2_signed) begin
               acc_result = prod_ext[ACC_WIDTH-1] ? SIGNED_MIN : SIGNED_MAX;
            end else begin
               acc_result = UNSIGNED_MAX;
            end
         end
      end
   end

   // Output register: holds its result for as long as downstream stalls
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         psum_out  <= '0;
         overflow  <= 1'b0;
      end else if (!stall) begin
         out_valid <= s2_valid;
         if (s2_valid) begin
            psum_out <= acc_result;
            overflow <= acc_ovf;
         end
      end
   end

endmodule

// File: tb/tb_pipelined_mac_unit.sv
// tb_pipelined_mac_unit
// Self-checking bench: one instance wraps on overflow, one saturates; both
// share every input. Directed cases use hand-computed constants, streamed
// cases use an integer-arithmetic reference model and an in-order queue.

module tb_pipelined_mac_unit;

   localparam int W1 = 8;
   localparam int W2 = 8;
   localparam int WA = 20;

   typedef struct packed {
      logic [WA-1:0] r_w;
      logic          o_w;
      logic [WA-1:0] r_s;
      logic          o_s;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic [W1-1:0] in1;
   logic [W2-1:0] in2;
   logic [WA-1:0] psum_in;
   logic          acc_en;
   logic          signed_mode;
   logic          out_ready;

   logic          in_ready_w, in_ready_s;
   logic          out_valid_w, out_valid_s;
   logic [WA-1:0] psum_out_w, psum_out_s;
   logic          overflow_w, overflow_s;
   exp_t          obs;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign obs = {psum_out_w, overflow_w, psum_out_s, overflow_s};

   pipelined_mac_unit #(.IN1_WIDTH(W1), .IN2_WIDTH(W2), .ACC_WIDTH(WA), .SATURATE(1'b0)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
      .in1(in1), .in2(in2), .psum_in(psum_in), .acc_en(acc_en), .signed_mode(signed_mode),
      .out_valid(out_valid_w), .out_ready(out_ready), .psum_out(psum_out_w), .overflow(overflow_w)
   );

   pipelined_mac_unit #(.IN1_WIDTH(W1), .IN2_WIDTH(W2), .ACC_WIDTH(WA), .SATURATE(1'b1)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
      .in1(in1), .in2(in2), .psum_in(psum_in), .acc_en(acc_en), .signed_mode(signed_mode),
      .out_valid(out_valid_s), .out_ready(out_ready), .psum_out(psum_out_s), .overflow(overflow_s)
   );

   // Reference: exact integer result, then range check, then wrap or clamp
   function automatic logic [WA:0] ref_mac(input logic [W1-1:0] a, input logic [W2-1:0] b,
                                           input logic [WA-1:0] p, input logic acc,
                                           input logic sgn, input logic sat);
      longint        total;
      longint        lim_hi;
      longint        lim_lo;
      logic          ovf;
      logic [WA-1:0] res;
      if (sgn) begin
         total = longint'($signed(a)) * longint'($signed(b));
         if (acc) total += longint'($signed(p));
         lim_hi = (longint'(1) << (WA - 1)) - 1;
         lim_lo = -(longint'(1) << (WA - 1));
         ovf    = (total > lim_hi) || (total < lim_lo);
         if (sat && ovf) res = (total > 0) ? WA'(lim_hi) : WA'(lim_lo);
         else            res = WA'(total);
      end else begin
         total = longint'(a) * longint'(b);
         if (acc) total += longint'(p);
         ovf = total > ((longint'(1) << WA) - 1);
         res = (sat && ovf) ? {WA{1'b1}} : WA'(total);
      end
      return {ovf, res};
   endfunction

   function automatic exp_t make_exp(input logic [W1-1:0] a, input logic [W2-1:0] b,
                                     input logic [WA-1:0] p, input logic acc, input logic sgn);
      logic [WA:0] w;
      logic [WA:0] s;
      w = ref_mac(a, b, p, acc, sgn, 1'b0);
      s = ref_mac(a, b, p, acc, sgn, 1'b1);
      return {w[WA-1:0], w[WA], s[WA-1:0], s[WA]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_random();
      logic [31:0] r0;
      logic [31:0] r1;
      r0          = $urandom;
      r1          = $urandom;
      in1         = r0[7:0];
      in2         = r0[15:8];
      acc_en      = r0[16];
      signed_mode = r0[17];
      // Half the time pick psum_in next to a range boundary to provoke overflow
      psum_in     = r0[18] ? {r1[19], {11{r1[18]}}, r1[7:0]} : r1[19:0];
   endtask

   // One isolated item: checks acceptance, 3-cycle latency, value, no repeat
   task automatic run_one(input string name, input logic [W1-1:0] a, input logic [W2-1:0] b,
                          input logic [WA-1:0] p, input logic acc, input logic sgn, input exp_t e);
      int lat;
      in1 = a; in2 = b; psum_in = p; acc_en = acc; signed_mode = sgn;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      checks++;
      if ({in_ready_w, in_ready_s} !== 2'b11) begin
         failures++;
         $display("FAIL %s_in_ready: got %b expected 11", name, {in_ready_w, in_ready_s});
      end
      lat = 0;
      do begin
         tick();
         in_valid = 1'b0;
         #1;
         lat++;
      end while (!out_valid_w && lat < 10);
      checks++;
      if (lat != 3 || out_valid_s !== 1'b1) begin
         failures++;
         $display("FAIL %s_latency: got %0d cycles (sat valid %b) expected 3", name, lat, out_valid_s);
      end
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL %s_value: got wrap=%h/%b sat=%h/%b expected wrap=%h/%b sat=%h/%b",
                  name, obs.r_w, obs.o_w, obs.r_s, obs.o_s, e.r_w, e.o_w, e.r_s, e.o_s);
      end
      tick();
      #1;
      checks++;
      if ({out_valid_w, out_valid_s} !== 2'b00) begin
         failures++;
         $display("FAIL %s_single: got out_valid %b expected 00", name, {out_valid_w, out_valid_s});
      end
   endtask

   // Scoreboarded stream: random items, either a fixed stall window or random
   // in_valid/out_ready; every presented result is compared with the queue head.
   task automatic run_stream(input string name, input int n_items, input bit fixed_stall);
      exp_t        q[$];
      int          sent;
      int          got;
      logic [31:0] r;
      logic        exp_rdy;
      sent = 0;
      got  = 0;
      for (int c = 0; c < 400 && got < n_items; c++) begin
         r = $urandom;
         if (fixed_stall) out_ready = !(c >= 4 && c <= 7);
         else             out_ready = (r[1:0] != 2'b00) || (sent == n_items);
         if (sent < n_items && (fixed_stall || r[3:2] != 2'b00)) begin
            drive_random();
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (fixed_stall) begin
            exp_rdy = !(c >= 4 && c <= 7);
            checks++;
            if (in_ready_w !== exp_rdy || in_ready_s !== exp_rdy) begin
               failures++;
               $display("FAIL %s_in_ready c=%0d: got %b%b expected %b", name, c, in_ready_w, in_ready_s, exp_rdy);
            end
         end
         if (out_valid_w || out_valid_s) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL %s_spurious c=%0d: got out_valid %b%b expected no result", name, c, out_valid_w, out_valid_s);
            end else if ({out_valid_w, out_valid_s} !== 2'b11 || obs !== q[0]) begin
               failures++;
               $display("FAIL %s_result c=%0d: got v=%b%b wrap=%h/%b sat=%h/%b expected wrap=%h/%b sat=%h/%b",
                        name, c, out_valid_w, out_valid_s, obs.r_w, obs.o_w, obs.r_s, obs.o_s,
                        q[0].r_w, q[0].o_w, q[0].r_s, q[0].o_s);
            end
            if (out_ready && q.size() != 0) begin
               q.delete(0);
               got++;
            end
         end
         if (in_valid && in_ready_w) begin
            q.push_back(make_exp(in1, in2, psum_in, acc_en, signed_mode));
            sent++;
         end
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (got != n_items || q.size() != 0) begin
         failures++;
         $display("FAIL %s_count: got %0d results (%0d pending) expected %0d", name, got, q.size(), n_items);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (2) tick();
      checks++;
      if ({out_valid_w, out_valid_s, in_ready_w, in_ready_s} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags: got %b expected 0000", {out_valid_w, out_valid_s, in_ready_w, in_ready_s});
      end
      checks++;
      if (obs !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got %h expected 0", obs);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if ({in_ready_w, in_ready_s} !== 2'b11) begin
         failures++;
         $display("FAIL reset_release_ready: got %b expected 11", {in_ready_w, in_ready_s});
      end
      tick();
   endtask

   task automatic test_unsigned_product();
      run_one("unsigned_255x255", 8'd255, 8'd255, 20'd0, 1'b0, 1'b0, {20'h0FE01, 1'b0, 20'h0FE01, 1'b0});
      run_one("unsigned_acc", 8'd200, 8'd100, 20'd12345, 1'b1, 1'b0, {20'd32345, 1'b0, 20'd32345, 1'b0});
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1; acc_en = 1'b0; signed_mode = 1'b1; psum_in = '0;
      in1 = 8'h80; in2 = 8'h80; in_valid = 1'b1;
      tick();
      in2 = 8'h7F;
      tick();
      in_valid = 1'b0;
      tick();
      checks++;
      if ({out_valid_w, out_valid_s} !== 2'b11 || obs !== {20'h04000, 1'b0, 20'h04000, 1'b0}) begin
         failures++;
         $display("FAIL b2b_first: got v=%b%b %h expected v=11 wrap=04000 sat=04000", out_valid_w, out_valid_s, obs);
      end
      tick();
      checks++;
      if ({out_valid_w, out_valid_s} !== 2'b11 || obs !== {20'hFC080, 1'b0, 20'hFC080, 1'b0}) begin
         failures++;
         $display("FAIL b2b_second: got v=%b%b %h expected v=11 wrap=fc080 sat=fc080", out_valid_w, out_valid_s, obs);
      end
      tick();
      checks++;
      if ({out_valid_w, out_valid_s} !== 2'b00) begin
         failures++;
         $display("FAIL b2b_drain: got out_valid %b expected 00", {out_valid_w, out_valid_s});
      end
   endtask

   task automatic test_accumulate();
      run_one("acc_signed", 8'd3, 8'd4, 20'd1000, 1'b1, 1'b1, {20'd1012, 1'b0, 20'd1012, 1'b0});
      run_one("acc_off", 8'd3, 8'd4, 20'd1000, 1'b0, 1'b1, {20'd12, 1'b0, 20'd12, 1'b0});
      run_one("acc_signed_neg", 8'hFD, 8'd4, 20'd5, 1'b1, 1'b1, {20'hFFFF9, 1'b0, 20'hFFFF9, 1'b0});
   endtask

   task automatic test_overflow();
      run_one("ovf_signed_pos", 8'd127, 8'd127, 20'h7FFFF, 1'b1, 1'b1, {20'h83F00, 1'b1, 20'h7FFFF, 1'b1});
      run_one("ovf_signed_neg", 8'h80, 8'd127, 20'h80000, 1'b1, 1'b1, {20'h7C080, 1'b1, 20'h80000, 1'b1});
      run_one("ovf_unsigned", 8'd1, 8'd1, 20'hFFFFF, 1'b1, 1'b0, {20'h00000, 1'b1, 20'hFFFFF, 1'b1});
      run_one("no_ovf_edge", 8'd0, 8'd9, 20'h7FFFF, 1'b1, 1'b1, {20'h7FFFF, 1'b0, 20'h7FFFF, 1'b0});
   endtask

   task automatic test_backpressure();
      run_stream("backpressure", 8, 1'b1);
   endtask

   task automatic test_random_stream();
      run_stream("random", 40, 1'b0);
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b0; acc_en = 1'b1; signed_mode = 1'b0; psum_in = 20'd7;
      for (int i = 0; i < 3; i++) begin
         in1 = 8'(i + 5); in2 = 8'd9; in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      checks++;
      if ({out_valid_w, in_ready_w, in_ready_s} !== 3'b100) begin
         failures++;
         $display("FAIL midflight_pre: got valid/ready %b expected 100", {out_valid_w, in_ready_w, in_ready_s});
      end
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1;
      checks++;
      if ({out_valid_w, out_valid_s} !== 2'b00 || obs !== '0 || {in_ready_w, in_ready_s} !== 2'b11) begin
         failures++;
         $display("FAIL midflight_cleared: got v=%b%b out=%h rdy=%b%b expected v=00 out=0 rdy=11",
                  out_valid_w, out_valid_s, obs, in_ready_w, in_ready_s);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if ({out_valid_w, out_valid_s} !== 2'b00) begin
            failures++;
            $display("FAIL midflight_discard cycle %0d: got out_valid %b expected 00", i, {out_valid_w, out_valid_s});
         end
      end
      run_one("after_reset", 8'd10, 8'd10, 20'd5, 1'b1, 1'b0, {20'd105, 1'b0, 20'd105, 1'b0});
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0; psum_in = '0;
      acc_en = 1'b0; signed_mode = 1'b0; out_ready = 1'b1;
      test_reset();
      test_unsigned_product();
      test_back_to_back();
      test_accumulate();
      test_overflow();
      test_backpressure();
      test_random_stream();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at time limit, expected completion");
      $fatal(1);
   end

endmodule
